// File: rtl/wimax_pkg.sv
// Constants, state encoding and LFSR helpers shared by the WiMAX PRBS
// randomizer and derandomizer (1 + x^14 + x^15 sequence).
package wimax_pkg;

    localparam int PRBS_W = 15;
    localparam int TAP_A  = 14;
    localparam int TAP_B  = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } derand_state_t;

    // Bit 1 is the feedback-input end; the register shifts towards bit PRBS_W.
    function automatic logic prbs_fb(input logic [1:PRBS_W] r);
        return r[TAP_A] ^ r[TAP_B];
    endfunction

    function automatic logic [1:PRBS_W] prbs_next(input logic [1:PRBS_W] r);
        return {prbs_fb(r), r[1:PRBS_W-1]};
    endfunction

endpackage

// File: rtl/bit_skid_fifo2.sv
// Two-entry FIFO of {bit, last} pairs with registered storage and count.
module bit_skid_fifo2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       push_bit,
    input  logic       push_last,
    input  logic       pop,
    output logic       head_bit,
    output logic       head_last,
    output logic [1:0] count
);

    logic [1:0] bit_mem_reg;
    logic [1:0] last_mem_reg;
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_push;
    logic       do_pop;

    assign do_push = push && (count_reg != 2'd2);
    assign do_pop  = pop && (count_reg != 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_mem_reg  <= 2'b00;
            last_mem_reg <= 2'b00;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
        end else begin
            if (do_push) begin
                bit_mem_reg[wr_ptr_reg]  <= push_bit;
                last_mem_reg[wr_ptr_reg] <= push_last;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Gate with occupancy so stale entries never show on the outputs.
    assign head_bit  = (count_reg != 2'd0) && bit_mem_reg[rd_ptr_reg];
    assign head_last = (count_reg != 2'd0) && last_mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/prbs_derand.sv
// Receive-side PRBS derandomizer: XORs each accepted bit with the LFSR
// keystream, buffers results in a 2-entry FIFO and tags the burst's last bit.
module prbs_derand
    import wimax_pkg::*;
#(
    parameter int BURST_BITS = 96,
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [1:PRBS_W] seed,
    input  logic            data_in,
    input  logic            valid_in,
    output logic            ready_derand,
    output logic            data_out,
    output logic            valid_out,
    output logic            last_out,
    input  logic            ready_sink
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_BITS - 1);

    derand_state_t   state_reg;
    derand_state_t   state_next;
    logic [1:PRBS_W] lfsr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]      fifo_count;
    logic            accept;
    logic            last_beat;
    logic            fb;

    assign fb        = prbs_fb(lfsr_reg);
    assign last_beat = (cnt_reg == LAST_IDX);

    // Uses only registered fifo_count, so there is no sink-to-source path.
    assign ready_derand = (state_reg != IDLE) && !load && (fifo_count < 2'd2);
    assign accept       = valid_in && ready_derand;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (load) begin
            state_next = ARMED;
        end else begin
            case (state_reg)
                IDLE: state_next = IDLE;
                ARMED: begin
                    if (accept) begin
                        state_next = last_beat ? IDLE : RUN;
                    end
                end
                RUN: begin
                    if (accept && last_beat) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            lfsr_reg <= seed;
            cnt_reg  <= '0;
        end else if (accept) begin
            lfsr_reg <= prbs_next(lfsr_reg);
            cnt_reg  <= cnt_reg + CNT_W'(1);
        end
    end

    bit_skid_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_bit  (data_in ^ fb),
        .push_last (last_beat),
        .pop       (valid_out && ready_sink),
        .head_bit  (data_out),
        .head_last (last_out),
        .count     (fifo_count)
    );

    assign valid_out = (fifo_count != 2'd0);

endmodule
